cache_block_ctrl: RTL and testbench

Cache-side coherence controller for one single-line cache block: the requesting end of the directory protocol carried on the 22-bit common data bus. It turns processor reads and writes into read-miss, write-miss and data-write-back messages. It answers directory-issued invalidate and fetch messages. It tracks the line as Invalid, Shared or Modified, mirroring the directory's Uncached, Shared and Exclusive states.

---
 rtl/coh_msg_pkg.sv | 51 +++++
 rtl/cache_block_ctrl_if.sv | 36 +++
 rtl/coh_emit_slot.sv | 52 +++++
 rtl/cache_block_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cache_block_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/coh_msg_pkg.sv
// -----------------------------------------------------------------------------
// coh_msg_pkg
// Shared definitions for the cache-side directory coherence controller:
//   - message codes carried in cdb/emit [21:16]
//   - line-state encodings aligned with the directory (I=00, S=01, M=10)
//   - controller FSM state encoding
//   - message field positions and a message builder helper
// -----------------------------------------------------------------------------
package coh_msg_pkg;

  // Message layout: [21:16] code, [15:0] address or data
  localparam int MSG_W     = 22;
  localparam int FIELD_W   = 16;
  localparam int CODE_MSB  = 21;
  localparam int CODE_LSB  = 16;
  localparam int FIELD_MSB = 15;
  localparam int FIELD_LSB = 0;

  // Message codes
  localparam logic [5:0] MSG_WRITE_MISS = 6'b000000;
  localparam logic [5:0] MSG_READ_MISS  = 6'b000001;
  localparam logic [5:0] MSG_INVALIDATE = 6'b000100;
  localparam logic [5:0] MSG_DATA_WB    = 6'b000101;
  localparam logic [5:0] MSG_DATA_REPLY = 6'b000110;
  localparam logic [5:0] MSG_FETCH      = 6'b100111;

  // Line-state encoding shared with the directory (Uncached/Shared/Exclusive)
  typedef enum logic [1:0] {
    LS_I = 2'b00,
    LS_S = 2'b01,
    LS_M = 2'b10
  } line_state_e;

  // Controller states; stable states keep the line-state code in the low bits
  typedef enum logic [2:0] {
    ST_I       = 3'b000,
    ST_S       = 3'b001,
    ST_M       = 3'b010,
    ST_WB_REPL = 3'b011,
    ST_MISS    = 3'b100,
    ST_WAIT    = 3'b101,
    ST_WB_DIR  = 3'b110
  } ctrl_state_e;

  // Build a bus message from a code and a 16-bit field
  function automatic logic [MSG_W-1:0] mk_msg(input logic [5:0] code,
                                              input logic [FIELD_W-1:0] field);
    return {code, field};
  endfunction

endpackage

// File: rtl/cache_block_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_block_ctrl_if
// Bundles the processor request port, the incoming directory bus (cdb) and the
// outgoing valid/ready message port of cache_block_ctrl.
//   slave  : controller side
//   master : processor / bus side (testbench)
// -----------------------------------------------------------------------------
interface cache_block_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Processor side
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  // Incoming directory messages
  logic          cdb_valid;
  logic [21:0]   cdb;
  // Outgoing messages
  logic          emit_valid;
  logic          emit_ready;
  logic [21:0]   emit;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cdb_valid, cdb, emit_ready,
    output cpu_ready, cpu_rdata, emit_valid, emit
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cdb_valid, cdb, emit_ready,
    input  cpu_ready, cpu_rdata, emit_valid, emit
  );
endinterface

// File: rtl/coh_emit_slot.sv
// -----------------------------------------------------------------------------
// coh_emit_slot
// Single-entry registered valid/ready output slot for outgoing messages.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i, msg_i : load a new message (FSM only loads when empty or accepting)
//   ready_i       : bus accepts the held message
//   valid_o, msg_o: registered message and its valid flag
// -----------------------------------------------------------------------------
module coh_emit_slot
  import coh_msg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [MSG_W-1:0] msg_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [MSG_W-1:0] msg_o
);

  logic             valid_q, valid_d;
  logic [MSG_W-1:0] msg_q,   msg_d;

  // Next-state: a load in the accepting cycle replaces the old message
  always_comb begin
    valid_d = valid_q;
    msg_d   = msg_q;
    if (load_i) begin
      valid_d = 1'b1;
      msg_d   = msg_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register; reset drops valid immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      msg_q   <= '0;
    end else begin
      valid_q <= valid_d;
      msg_q   <= msg_d;
    end
  end

  assign valid_o = valid_q;
  assign msg_o   = msg_q;

endmodule

// File: rtl/cache_block_ctrl.sv
// -----------------------------------------------------------------------------
// cache_block_ctrl
// Requesting-side coherence controller for a single cache line. Converts
// processor reads/writes into read-miss / write-miss / write-back messages and
// answers directory invalidate and fetch messages.
//   clock   : rising-edge clock
//   reset_n : async active-low reset
//   bus     : cache_block_ctrl_if.slave (cpu_*, cdb*, emit*)
// -----------------------------------------------------------------------------
module cache_block_ctrl
  import coh_msg_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  cache_block_ctrl_if.slave  bus
);

  ctrl_state_e      state_q, state_d;
  logic [AW-1:0]    line_addr_q, line_addr_d;
  logic [DW-1:0]    line_data_q, line_data_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic             wb_to_s_q, wb_to_s_d;   // WB_DIR exit target: 1 = S (fetch), 0 = I

  logic             slot_load_s;
  logic [MSG_W-1:0] slot_msg_s;
  logic             slot_valid_s;
  logic [MSG_W-1:0] slot_out_s;

  logic [5:0]       cdb_code_s;
  logic [15:0]      cdb_field_s;
  logic             dir_match_s;
  logic             dir_inv_s;
  logic             dir_fetch_s;
  logic             req_s;
  logic             hit_s;
  logic             accept_s;
  logic [5:0]       miss_code_s;

  assign cdb_code_s  = bus.cdb[CODE_MSB:CODE_LSB];
  assign cdb_field_s = bus.cdb[FIELD_MSB:FIELD_LSB];
  assign dir_match_s = bus.cdb_valid && (cdb_field_s == line_addr_q);
  assign dir_inv_s   = dir_match_s && (cdb_code_s == MSG_INVALIDATE);
  assign dir_fetch_s = dir_match_s && (cdb_code_s == MSG_FETCH);
  // The cycle cpu_ready is high still sees cpu_req asserted; it is not a new request
  assign req_s       = bus.cpu_req && !cpu_ready_q;
  assign hit_s       = (bus.cpu_addr == line_addr_q);
  assign accept_s    = slot_valid_s && bus.emit_ready;
  assign miss_code_s = bus.cpu_we ? MSG_WRITE_MISS : MSG_READ_MISS;

  // Next-state, line update and message-load decisions
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    wb_to_s_d   = wb_to_s_q;
    slot_load_s = 1'b0;
    slot_msg_s  = '0;

    case (state_q)
      ST_I: begin
        if (req_s) begin
          state_d     = ST_MISS;
          slot_load_s = 1'b1;
          slot_msg_s  = mk_msg(miss_code_s, bus.cpu_addr);
        end else begin
          state_d = ST_I;
        end
      end

      ST_S: begin
        if (dir_inv_s) begin
          state_d = ST_I;
        end else if (req_s) begin
          if (hit_s && !bus.cpu_we) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = line_data_q;
          end else begin
            // Upgrade or miss: a clean line is dropped without write-back
            state_d     = ST_MISS;
            slot_load_s = 1'b1;
            slot_msg_s  = mk_msg(miss_code_s, bus.cpu_addr);
          end
        end else begin
          state_d = ST_S;
        end
      end

      ST_M: begin
        if (dir_inv_s || dir_fetch_s) begin
          state_d     = ST_WB_DIR;
          wb_to_s_d   = dir_fetch_s;
          slot_load_s = 1'b1;
          slot_msg_s  = mk_msg(MSG_DATA_WB, line_data_q);
        end else if (req_s) begin
          if (hit_s && !bus.cpu_we) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = line_data_q;
          end else if (hit_s) begin
            cpu_ready_d = 1'b1;
            line_data_d = bus.cpu_wdata;
          end else begin
            state_d     = ST_WB_REPL;
            slot_load_s = 1'b1;
            slot_msg_s  = mk_msg(MSG_DATA_WB, line_data_q);
          end
        end else begin
          state_d = ST_M;
        end
      end

      ST_WB_REPL: begin
        // Miss message is loaded into the slot as the write-back leaves it
        if (accept_s) begin
          state_d     = ST_MISS;
          slot_load_s = 1'b1;
          slot_msg_s  = mk_msg(miss_code_s, bus.cpu_addr);
        end else begin
          state_d = ST_WB_REPL;
        end
      end

      ST_MISS: begin
        if (accept_s) begin
          state_d     = ST_WAIT;
          line_addr_d = bus.cpu_addr;
        end else begin
          state_d = ST_MISS;
        end
      end

      ST_WAIT: begin
        if (bus.cdb_valid && (cdb_code_s == MSG_DATA_REPLY)) begin
          cpu_ready_d = 1'b1;
          if (bus.cpu_we) begin
            state_d     = ST_M;
            line_data_d = bus.cpu_wdata;
          end else begin
            state_d     = ST_S;
            line_data_d = cdb_field_s;
            cpu_rdata_d = cdb_field_s;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WB_DIR: begin
        if (accept_s) begin
          state_d = wb_to_s_q ? ST_S : ST_I;
        end else begin
          state_d = ST_WB_DIR;
        end
      end

      default: begin
        state_d = ST_I;
      end
    endcase
  end

  // State and line registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_I;
      line_addr_q <= '0;
      line_data_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      wb_to_s_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      wb_to_s_q   <= wb_to_s_d;
    end
  end

  coh_emit_slot u_emit_slot (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .load_i  (slot_load_s),
    .msg_i   (slot_msg_s),
    .ready_i (bus.emit_ready),
    .valid_o (slot_valid_s),
    .msg_o   (slot_out_s)
  );

  assign bus.emit_valid = slot_valid_s;
  assign bus.emit       = slot_out_s;
  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_cache_block_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_block_ctrl
// Directed bench for cache_block_ctrl. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_cache_block_ctrl;
  import coh_msg_pkg::*;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  cache_block_ctrl_if #(.AW(16), .DW(16)) bus_if ();

  cache_block_ctrl #(.AW(16), .DW(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // 10 time-unit clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    clock   = 1'b0;
    reset_n = 1'b0;
    total   = 0;
    bad     = 0;
    bus_if.cpu_req    = 1'b0;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_addr   = 16'h0000;
    bus_if.cpu_wdata  = 16'h0000;
    bus_if.cdb_valid  = 1'b0;
    bus_if.cdb        = 22'h000000;
    bus_if.emit_ready = 1'b0;

    // ---- reset values
    step(); step();
    check("rst_emit_valid", 32'(bus_if.emit_valid), 32'h0);
    check("rst_emit",       32'(bus_if.emit),       32'h0);
    check("rst_cpu_ready",  32'(bus_if.cpu_ready),  32'h0);
    check("rst_cpu_rdata",  32'(bus_if.cpu_rdata),  32'h0);
    check("rst_state",      32'(dut.state_q),       32'(ST_I));
    reset_n = 1'b1;
    step();

    // ---- read miss 0x0040, reply 0xBEEF
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h0040;
    step();
    check("rm_emit_valid", 32'(bus_if.emit_valid), 32'h1);
    check("rm_emit",       32'(bus_if.emit),       32'({6'b000001, 16'h0040}));
    check("rm_no_ready",   32'(bus_if.cpu_ready),  32'h0);
    bus_if.emit_ready = 1'b1;
    step();
    bus_if.emit_ready = 1'b0;
    check("rm_emit_clear", 32'(bus_if.emit_valid), 32'h0);
    check("rm_state_wait", 32'(dut.state_q),       32'(ST_WAIT));
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000110, 16'hBEEF};
    step();
    bus_if.cdb_valid = 1'b0;
    check("rm_ready",   32'(bus_if.cpu_ready), 32'h1);
    check("rm_rdata",   32'(bus_if.cpu_rdata), 32'hBEEF);
    check("rm_state_s", 32'(dut.state_q),      32'(ST_S));
    bus_if.cpu_req = 1'b0;
    step();
    check("rm_ready_pulse", 32'(bus_if.cpu_ready), 32'h0);

    // ---- write hit in S (upgrade), reply, then read hit
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1;
    bus_if.cpu_addr = 16'h0040; bus_if.cpu_wdata = 16'h1234;
    step();
    check("up_emit_valid", 32'(bus_if.emit_valid), 32'h1);
    check("up_emit",       32'(bus_if.emit),       32'({6'b000000, 16'h0040}));
    bus_if.emit_ready = 1'b1;
    step();
    bus_if.emit_ready = 1'b0;
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000110, 16'h5555};
    step();
    bus_if.cdb_valid = 1'b0;
    check("up_ready",   32'(bus_if.cpu_ready), 32'h1);
    check("up_state_m", 32'(dut.state_q),      32'(ST_M));
    bus_if.cpu_req = 1'b0;
    step();
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h0040;
    step();
    check("rh_ready",   32'(bus_if.cpu_ready),  32'h1);
    check("rh_rdata",   32'(bus_if.cpu_rdata),  32'h1234);
    check("rh_no_emit", 32'(bus_if.emit_valid), 32'h0);
    bus_if.cpu_req = 1'b0;
    step();

    // ---- replacement from M: write-back held under back-pressure, then read miss
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wbr_emit_valid", 32'(bus_if.emit_valid), 32'h1);
      check("wbr_emit",       32'(bus_if.emit),       32'({6'b000101, 16'h1234}));
    end
    bus_if.emit_ready = 1'b1;
    step();
    check("wbr_miss_valid", 32'(bus_if.emit_valid), 32'h1);
    check("wbr_miss_emit",  32'(bus_if.emit),       32'({6'b000001, 16'h0080}));
    step();
    bus_if.emit_ready = 1'b0;
    check("wbr_emit_clear", 32'(bus_if.emit_valid), 32'h0);
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000110, 16'hCAFE};
    step();
    bus_if.cdb_valid = 1'b0;
    check("wbr_ready", 32'(bus_if.cpu_ready), 32'h1);
    check("wbr_rdata", 32'(bus_if.cpu_rdata), 32'hCAFE);
    bus_if.cpu_req = 1'b0;
    step();

    // ---- write miss from S back to 0x0040 -> M with 0xABCD
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1;
    bus_if.cpu_addr = 16'h0040; bus_if.cpu_wdata = 16'hABCD;
    step();
    check("wm_emit", 32'(bus_if.emit), 32'({6'b000000, 16'h0040}));
    bus_if.emit_ready = 1'b1;
    step();
    bus_if.emit_ready = 1'b0;
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000110, 16'h0000};
    step();
    bus_if.cdb_valid = 1'b0;
    check("wm_ready",   32'(bus_if.cpu_ready), 32'h1);
    check("wm_state_m", 32'(dut.state_q),      32'(ST_M));
    bus_if.cpu_req = 1'b0;
    step();

    // ---- fetch to a different address is ignored
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b100111, 16'h0044};
    step();
    bus_if.cdb_valid = 1'b0;
    check("fx_no_emit", 32'(bus_if.emit_valid), 32'h0);
    check("fx_state_m", 32'(dut.state_q),       32'(ST_M));

    // ---- matching fetch in M: write-back, then S
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b100111, 16'h0040};
    step();
    bus_if.cdb_valid = 1'b0;
    check("fm_emit_valid", 32'(bus_if.emit_valid), 32'h1);
    check("fm_emit",       32'(bus_if.emit),       32'({6'b000101, 16'hABCD}));
    bus_if.emit_ready = 1'b1;
    step();
    bus_if.emit_ready = 1'b0;
    check("fm_state_s",    32'(dut.state_q),       32'(ST_S));
    check("fm_emit_clear", 32'(bus_if.emit_valid), 32'h0);

    // ---- same-cycle invalidate and read hit in S: invalidate wins
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000100, 16'h0040};
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h0040;
    step();
    bus_if.cdb_valid = 1'b0;
    check("inv_no_ready", 32'(bus_if.cpu_ready),  32'h0);
    check("inv_state_i",  32'(dut.state_q),       32'(ST_I));
    check("inv_no_emit",  32'(bus_if.emit_valid), 32'h0);
    step();
    check("inv_rm_valid", 32'(bus_if.emit_valid), 32'h1);
    check("inv_rm_emit",  32'(bus_if.emit),       32'({6'b000001, 16'h0040}));
    bus_if.emit_ready = 1'b1;
    step();
    bus_if.emit_ready = 1'b0;
    check("inv_state_wait", 32'(dut.state_q), 32'(ST_WAIT));

    // ---- async reset while in WAIT; a reply arriving under reset is lost
    bus_if.cdb_valid = 1'b1; bus_if.cdb = {6'b000110, 16'h1111};
    #2 reset_n = 1'b0;
    #1;
    check("rw_emit_valid", 32'(bus_if.emit_valid), 32'h0);
    check("rw_state_i",    32'(dut.state_q),       32'(ST_I));
    step();
    check("rw_no_ready", 32'(bus_if.cpu_ready), 32'h0);
    bus_if.cdb_valid = 1'b0;
    bus_if.cpu_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("rw_no_ready2", 32'(bus_if.cpu_ready), 32'h0);
    check("rw_rdata",     32'(bus_if.cpu_rdata), 32'h0);
    check("rw_state_i2",  32'(dut.state_q),      32'(ST_I));

    // ---- async reset while a message is pending on emit
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 16'h0100;
    step();
    check("re_emit_valid", 32'(bus_if.emit_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("re_emit_drop", 32'(bus_if.emit_valid), 32'h0);
    check("re_emit_zero", 32'(bus_if.emit),       32'h0);
    bus_if.cpu_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("re_state_i",  32'(dut.state_q),       32'(ST_I));
    check("re_no_emit",  32'(bus_if.emit_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
